// File: rtl/ecdsa_scalar_prep.sv
// ecdsa_scalar_prep
// Front end of the ECDSA verifier. Range-checks the signature scalars r and s
// against the group order n. It then computes w = s^-1 mod n with a binary
// extended-Euclid engine (one step per cycle). Finally it forms u1 = e*w mod n
// and u2 = r*w mod n with two bit-serial (MSB-first) modular multipliers that
// run side by side.
//
// Ports
//   clk     in   1    system clock, all state on the rising edge
//   rst     in   1    synchronous, active-high reset
//   go      in   1    start request, held until done is seen
//   e       in   K    hashed message (any value, reduced by the multiplier)
//   r       in   K    signature r
//   s       in   K    signature s
//   n       in   K    group order (odd prime)
//   ready   out  1    1 while idle and able to accept go
//   done    out  1    1 while results are presented
//   sig_ok  out  1    1 = scalars valid and u1/u2 meaningful, 0 = reject
//   u1      out  K    e*s^-1 mod n (0 on reject)
//   u2      out  K    r*s^-1 mod n (0 on reject)
module ecdsa_scalar_prep #(
    parameter int KEY_SIZE = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [KEY_SIZE-1:0] e,
    input  logic [KEY_SIZE-1:0] r,
    input  logic [KEY_SIZE-1:0] s,
    input  logic [KEY_SIZE-1:0] n,
    output logic                ready,
    output logic                done,
    output logic                sig_ok,
    output logic [KEY_SIZE-1:0] u1,
    output logic [KEY_SIZE-1:0] u2
);

    localparam int K   = KEY_SIZE;
    localparam int ITW = $clog2(4 * K + 1);
    localparam int CW  = $clog2(K);

    localparam logic [K-1:0]   ZERO_K   = {K{1'b0}};
    localparam logic [K-1:0]   ONE_K    = {{(K-1){1'b0}}, 1'b1};
    localparam logic [K-1:0]   THREE_K  = {{(K-2){1'b0}}, 2'b11};
    localparam logic [ITW-1:0] ITER_MAX = ITW'(4 * K);
    localparam logic [ITW-1:0] ITER_ONE = {{(ITW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  BIT_LAST = CW'(K - 1);
    localparam logic [CW-1:0]  BIT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  BIT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_INV   = 3'd3,
        ST_MUL   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // x/2 mod m for odd m: when x is odd, x+m is even. The sum needs K+1 bits.
    function automatic logic [K-1:0] half_mod(input logic [K-1:0] x, input logic [K-1:0] m);
        logic [K:0] t;
        if (x[0]) begin
            t = {1'b0, x} + {1'b0, m};
        end else begin
            t = {1'b0, x};
        end
        return t[K:1];
    endfunction

    // (a - b) mod m with a, b < m.
    function automatic logic [K-1:0] sub_mod(input logic [K-1:0] a, input logic [K-1:0] b,
                                             input logic [K-1:0] m);
        logic [K:0] t;
        if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return t[K-1:0];
    endfunction

    // One Horner step: (2*acc + (bit ? w : 0)) mod m. Each reduction is a single
    // conditional subtract, because acc < m and w < m.
    function automatic logic [K-1:0] dbl_add_mod(input logic [K-1:0] acc, input logic b,
                                                 input logic [K-1:0] w, input logic [K-1:0] m);
        logic [K:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end else begin
            t = t;
        end
        if (b) begin
            t = t + {1'b0, w};
        end else begin
            t = t;
        end
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end else begin
            t = t;
        end
        return t[K-1:0];
    endfunction

    state_t         state_q, state_d;
    logic [K-1:0]   e_q, e_d, r_q, r_d, s_q, s_d, n_q, n_d;
    logic [K-1:0]   u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, w_q, w_d;
    logic [K-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic [ITW-1:0] iter_q, iter_d;
    logic [CW-1:0]  bit_q, bit_d;
    logic           ready_q, ready_d, done_q, done_d, sig_ok_q, sig_ok_d;
    logic [K-1:0]   u1_q, u1_d, u2_q, u2_d;
    logic           range_err_s;

    // Scalar range check on the latched operands.
    always_comb begin
        range_err_s = (n_q[0] == 1'b0) || (n_q < THREE_K) ||
                      (r_q == ZERO_K) || (r_q >= n_q) ||
                      (s_q == ZERO_K) || (s_q >= n_q);
    end

    // Next-state and datapath logic for the whole sequencer.
    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        r_d      = r_q;
        s_d      = s_q;
        n_d      = n_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        w_d      = w_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        iter_d   = iter_q;
        bit_d    = bit_q;
        sig_ok_d = sig_ok_q;
        u1_d     = u1_q;
        u2_d     = u2_q;

        case (state_q)
            ST_WAIT: begin
                if (go) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_LOAD: begin
                e_d     = e;
                r_d     = r;
                s_d     = s;
                n_d     = n;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (range_err_s) begin
                    sig_ok_d = 1'b0;
                    u1_d     = ZERO_K;
                    u2_d     = ZERO_K;
                    state_d  = ST_DONE;
                end else begin
                    u_d     = s_q;
                    v_d     = n_q;
                    x1_d    = ONE_K;
                    x2_d    = ZERO_K;
                    iter_d  = {ITW{1'b0}};
                    state_d = ST_INV;
                end
            end
            ST_INV: begin
                // Invariants: x1*s == u and x2*s == v (mod n).
                iter_d = iter_q + ITER_ONE;
                if (u_q == ONE_K) begin
                    w_d     = x1_q;
                    a1_d    = ZERO_K;
                    a2_d    = ZERO_K;
                    bit_d   = BIT_LAST;
                    state_d = ST_MUL;
                end else if (v_q == ONE_K) begin
                    w_d     = x2_q;
                    a1_d    = ZERO_K;
                    a2_d    = ZERO_K;
                    bit_d   = BIT_LAST;
                    state_d = ST_MUL;
                end else if ((u_q == ZERO_K) || (v_q == ZERO_K) || (iter_q == ITER_MAX)) begin
                    sig_ok_d = 1'b0;
                    u1_d     = ZERO_K;
                    u2_d     = ZERO_K;
                    state_d  = ST_DONE;
                end else if (u_q[0] == 1'b0) begin
                    u_d  = {1'b0, u_q[K-1:1]};
                    x1_d = half_mod(x1_q, n_q);
                end else if (v_q[0] == 1'b0) begin
                    v_d  = {1'b0, v_q[K-1:1]};
                    x2_d = half_mod(x2_q, n_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q, n_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q, n_q);
                end
            end
            ST_MUL: begin
                a1_d = dbl_add_mod(a1_q, e_q[bit_q], w_q, n_q);
                a2_d = dbl_add_mod(a2_q, r_q[bit_q], w_q, n_q);
                if (bit_q == BIT_ZERO) begin
                    u1_d     = a1_d;
                    u2_d     = a2_d;
                    sig_ok_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    bit_d = bit_q - BIT_ONE;
                end
            end
            ST_DONE: begin
                // No auto-restart: go must drop before a new request is taken.
                if (go) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // Handshake outputs are decoded from the next state so they register in step.
        ready_d = (state_d == ST_WAIT);
        done_d  = (state_d == ST_DONE);
    end

    // State register with synchronous reset. Reset discards any work in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_WAIT;
            e_q      <= ZERO_K;
            r_q      <= ZERO_K;
            s_q      <= ZERO_K;
            n_q      <= ZERO_K;
            u_q      <= ZERO_K;
            v_q      <= ZERO_K;
            x1_q     <= ZERO_K;
            x2_q     <= ZERO_K;
            w_q      <= ZERO_K;
            a1_q     <= ZERO_K;
            a2_q     <= ZERO_K;
            iter_q   <= {ITW{1'b0}};
            bit_q    <= BIT_ZERO;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            sig_ok_q <= 1'b0;
            u1_q     <= ZERO_K;
            u2_q     <= ZERO_K;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            r_q      <= r_d;
            s_q      <= s_d;
            n_q      <= n_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            w_q      <= w_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            iter_q   <= iter_d;
            bit_q    <= bit_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            sig_ok_q <= sig_ok_d;
            u1_q     <= u1_d;
            u2_q     <= u2_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign sig_ok = sig_ok_q;
    assign u1     = u1_q;
    assign u2     = u2_q;

endmodule

// File: tb/tb_ecdsa_scalar_prep.sv
// Self-checking bench for ecdsa_scalar_prep. Expected values come from a
// plain-arithmetic model: Fermat inversion and wide multiply with %.
module tb_ecdsa_scalar_prep;

    localparam int K = 256;
    localparam logic [K-1:0] N_K1 =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

    logic         clk;
    logic         rst;
    logic         go;
    logic [K-1:0] e, r, s, n;
    logic         ready, done, sig_ok;
    logic [K-1:0] u1, u2;

    int checks_total  = 0;
    int checks_passed = 0;

    ecdsa_scalar_prep #(.KEY_SIZE(K)) dut (
        .clk(clk), .rst(rst), .go(go), .e(e), .r(r), .s(s), .n(n),
        .ready(ready), .done(done), .sig_ok(sig_ok), .u1(u1), .u2(u2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp_v);
        checks_total++;
        if (obs === exp_v) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [K-1:0] mulmod(input logic [K-1:0] a, input logic [K-1:0] b,
                                            input logic [K-1:0] m);
        logic [2*K-1:0] p;
        logic [2*K-1:0] q;
        p = {{K{1'b0}}, a} * {{K{1'b0}}, b};
        q = p % {{K{1'b0}}, m};
        return q[K-1:0];
    endfunction

    // a^(m-2) mod m, valid for prime m.
    function automatic logic [K-1:0] invmod(input logic [K-1:0] a, input logic [K-1:0] m);
        logic [K-1:0] x;
        logic [K-1:0] res;
        x   = m - 2;
        res = 1;
        for (int i = K - 1; i >= 0; i--) begin
            res = mulmod(res, res, m);
            if (x[i]) res = mulmod(res, a, m);
        end
        return res;
    endfunction

    function automatic bit scalars_ok(input logic [K-1:0] tr, input logic [K-1:0] ts,
                                      input logic [K-1:0] tn);
        return tn[0] && (tn >= 3) && (tr != 0) && (tr < tn) && (ts != 0) && (ts < tn);
    endfunction

    function automatic logic [K-1:0] rand_k();
        logic [K-1:0] v;
        v = 0;
        for (int i = 0; i < K / 32; i++) v = {v[K-33:0], 32'($urandom())};
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Raises go and counts clock edges until done (bounded). With scramble set,
    // the operand inputs are changed once they have been latched.
    task automatic run_sig(input logic [K-1:0] te, input logic [K-1:0] tr,
                           input logic [K-1:0] ts, input logic [K-1:0] tn,
                           input bit scramble, output int lat);
        @(negedge clk);
        e = te; r = tr; s = ts; n = tn; go = 1'b1;
        lat = 0;
        for (int c = 0; c < 5 * K + 20; c++) begin
            @(negedge clk);
            lat++;
            if (scramble && lat == 2) begin
                e = rand_k(); r = rand_k(); s = rand_k(); n = rand_k();
            end
            if (done) break;
        end
    endtask

    task automatic release_go(input string tag);
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        check_val({tag, "_ready"}, K'(ready), K'(1));
        check_val({tag, "_done_low"}, K'(done), K'(0));
    endtask

    // Runs one request and compares everything against the model.
    task automatic check_vec(input string tag, input logic [K-1:0] te, input logic [K-1:0] tr,
                             input logic [K-1:0] ts, input logic [K-1:0] tn, input bit scramble);
        int           lat;
        bit           ok;
        logic [K-1:0] w, x1, x2;
        run_sig(te, tr, ts, tn, scramble, lat);
        ok = scalars_ok(tr, ts, tn);
        if (ok) begin
            w  = invmod(ts, tn);
            x1 = mulmod(te, w, tn);
            x2 = mulmod(tr, w, tn);
        end else begin
            x1 = 0;
            x2 = 0;
        end
        check_val({tag, "_done"}, K'(done), K'(1));
        check_val({tag, "_sig_ok"}, K'(sig_ok), K'(ok));
        check_val({tag, "_u1"}, u1, x1);
        check_val({tag, "_u2"}, u2, x2);
        if (ok) check_val({tag, "_lat_bound"}, K'(lat <= 5 * K + 3), K'(1));
        else    check_val({tag, "_lat_reject"}, K'(lat), K'(3));
    endtask

    initial begin
        int           held;
        int           lat;
        logic [K-1:0] tr, ts, te;

        rst = 1'b1; go = 1'b0; e = 0; r = 0; s = 0; n = 0;
        repeat (2) @(negedge clk);
        check_val("rst_ready", K'(ready), K'(1));
        check_val("rst_done", K'(done), K'(0));
        check_val("rst_sig_ok", K'(sig_ok), K'(0));
        check_val("rst_u1", u1, K'(0));
        check_val("rst_u2", u2, K'(0));
        rst = 1'b0;

        // Worked example, with the inputs disturbed after they are latched.
        check_vec("ex23", K'(10), K'(7), K'(5), K'(23), 1'b1);
        check_val("ex23_u1_const", u1, K'(2));
        check_val("ex23_u2_const", u2, K'(6));
        release_go("ex23");

        // Range rejections.
        check_vec("s_zero", K'(10), K'(7), K'(0), K'(23), 1'b0);
        release_go("s_zero");
        check_vec("r_eq_n", K'(10), K'(23), K'(5), K'(23), 1'b0);
        release_go("r_eq_n");
        check_vec("n_even", K'(3), K'(1), K'(1), K'(24), 1'b0);
        release_go("n_even");
        check_vec("s_eq_n", K'(3), K'(1), K'(23), K'(23), 1'b0);
        release_go("s_eq_n");

        // s = 1, e >= n; then go held in the result state.
        check_vec("s_one", K'(50), K'(22), K'(1), K'(23), 1'b0);
        check_val("s_one_u1_const", u1, K'(4));
        held = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done && !ready) held++;
        end
        check_val("hold_done_cycles", K'(held), K'(10));
        check_val("hold_u2", u2, K'(22));
        release_go("hold");

        // Reset in the middle of the inversion.
        @(negedge clk);
        e = 10; r = 7; s = 5; n = 23; go = 1'b1;
        repeat (4) @(negedge clk);
        check_val("mid_busy", K'(ready), K'(0));
        rst = 1'b1; go = 1'b0;
        @(negedge clk);
        check_val("mid_rst_ready", K'(ready), K'(1));
        check_val("mid_rst_done", K'(done), K'(0));
        check_val("mid_rst_sig_ok", K'(sig_ok), K'(0));
        rst = 1'b0;
        check_vec("after_rst", K'(10), K'(7), K'(5), K'(23), 1'b0);
        release_go("after_rst");

        // Random vectors over secp256k1; every 16th has an out-of-range s.
        for (int v = 0; v < 64; v++) begin
            do tr = rand_k(); while (tr == 0 || tr >= N_K1);
            do ts = rand_k(); while (ts == 0 || ts >= N_K1);
            te = rand_k();
            if (v % 16 == 15) ts = N_K1 + K'(v);
            check_vec($sformatf("rnd%0d", v), te, tr, ts, N_K1, 1'b0);
            @(negedge clk);
            go = 1'b0;
            lat = 0;
            while (!ready && lat < 8) begin
                @(negedge clk);
                lat++;
            end
        end
        check_val("final_ready", K'(ready), K'(1));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
